// File: rtl/vt_pkg.sv
// rtl/vt_pkg.sv - shared state encoding and LFSR constants for variable_table_bank.
package vt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    READY = 2'd2
  } vt_state_e;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'h0001;

  // Galois right-shift step; bit0 of the current state is the emitted bit.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/variable_table_bank_if.sv
// rtl/variable_table_bank_if.sv - host-facing bundle: init control, flip port, parallel read ports.
interface vt_if #(
  parameter int VAR_ADDR_W   = 11,
  parameter int NUM_RD_PORTS = 60,
  parameter int SEED_W       = 16
);
  logic                               init_start;
  logic [SEED_W-1:0]                  init_seed;
  logic                               init_done;
  logic                               ready;
  logic                               flip_valid;
  logic [VAR_ADDR_W-1:0]              flip_addr;
  logic                               flip_ready;
  logic [NUM_RD_PORTS-1:0]            rd_en;
  logic [NUM_RD_PORTS*VAR_ADDR_W-1:0] rd_addr;
  logic [NUM_RD_PORTS-1:0]            rd_data;
  logic [NUM_RD_PORTS-1:0]            rd_valid;

  modport master (
    output init_start, init_seed, flip_valid, flip_addr, rd_en, rd_addr,
    input  init_done, ready, flip_ready, rd_data, rd_valid
  );

  modport slave (
    input  init_start, init_seed, flip_valid, flip_addr, rd_en, rd_addr,
    output init_done, ready, flip_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/vt_replica.sv
// rtl/vt_replica.sv - 1-bit simple dual-port RAM, one write port and a read-first registered read port.
module vt_replica #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rdata
);

  logic mem [2**ADDR_W];
  logic rdata_q;
  logic rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output holds its last value while re is low.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= 1'b0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/variable_table_bank.sv
// rtl/variable_table_bank.sv - replicated variable store with init sweep, pipelined broadcast flip and read bypass.
// VT_LFSR_INIT_EN selects LFSR fill during the sweep; undefined fills zeros.
module variable_table_bank
  import vt_pkg::*;
#(
  parameter int VAR_ADDR_W   = 11,
  parameter int NUM_RD_PORTS = 60,
  parameter int SEED_W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  vt_if.slave  bus
);

  localparam logic [VAR_ADDR_W-1:0] LAST_ADDR = {VAR_ADDR_W{1'b1}};

  vt_state_e               state_q, state_d;
  logic [VAR_ADDR_W-1:0]   cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    init_done_q, init_done_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [VAR_ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic                    fwd_q, fwd_d;
  logic                    fwd_val_q, fwd_val_d;
  logic [NUM_RD_PORTS-1:0] rd_valid_q, rd_valid_d;
  logic [NUM_RD_PORTS-1:0] byp_q, byp_d;
  logic [NUM_RD_PORTS-1:0] byp_val_q, byp_val_d;

  logic                    accept;
  logic                    s1_old;
  logic                    init_bit;
  logic                    wr_en;
  logic [VAR_ADDR_W-1:0]   wr_addr;
  logic                    wr_data;
  logic                    master_rdata;
  logic [NUM_RD_PORTS-1:0] rep_rdata;
  logic [SEED_W-1:0]       seed;

  assign seed   = bus.init_seed;
  assign accept = bus.flip_valid & ready_q;
  // A flip that read the master while S1 wrote the same address saw stale data.
  assign s1_old = fwd_q ? fwd_val_q : master_rdata;

  assign wr_en   = (state_q == INIT) | s1_valid_q;
  assign wr_addr = (state_q == INIT) ? cnt_q : s1_addr_q;
  assign wr_data = (state_q == INIT) ? init_bit : ~s1_old;

`ifdef VT_LFSR_INIT_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.init_start)       lfsr_d = (seed == '0) ? LFSR_DEFAULT_SEED : 16'(seed);
    else if (state_q == INIT) lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_DEFAULT_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign init_bit = lfsr_q[0];
`else
  logic unused_seed;
  assign unused_seed = ^seed;
  assign init_bit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = 1'b0;
    s1_valid_d  = accept;
    s1_addr_d   = accept ? bus.flip_addr : s1_addr_q;
    fwd_d       = accept & s1_valid_q & (bus.flip_addr == s1_addr_q);
    fwd_val_d   = wr_data;
    if (bus.init_start) begin
      state_d    = INIT;
      cnt_d      = '0;
      s1_valid_d = 1'b0;
      fwd_d      = 1'b0;
    end else if (state_q == INIT) begin
      cnt_d = cnt_q + VAR_ADDR_W'(1);
      if (cnt_q == LAST_ADDR) begin
        state_d     = READY;
        init_done_d = 1'b1;
        cnt_d       = '0;
      end
    end
    ready_d = (state_d == READY);
  end

  // A read landing on the address being written this cycle takes the written value.
  always_comb begin
    rd_valid_d = bus.rd_en;
    byp_d      = byp_q;
    byp_val_d  = byp_val_q;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      if (bus.rd_en[i]) begin
        byp_d[i]     = wr_en & (bus.rd_addr[i*VAR_ADDR_W +: VAR_ADDR_W] == wr_addr);
        byp_val_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      fwd_q       <= 1'b0;
      fwd_val_q   <= 1'b0;
      rd_valid_q  <= '0;
      byp_q       <= '0;
      byp_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      fwd_q       <= fwd_d;
      fwd_val_q   <= fwd_val_d;
      rd_valid_q  <= rd_valid_d;
      byp_q       <= byp_d;
      byp_val_q   <= byp_val_d;
    end
  end

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rep
    vt_replica #(.ADDR_W(VAR_ADDR_W)) u_rep (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (bus.rd_en[i]),
      .raddr (bus.rd_addr[i*VAR_ADDR_W +: VAR_ADDR_W]),
      .rdata (rep_rdata[i])
    );
  end

  vt_replica #(.ADDR_W(VAR_ADDR_W)) u_master (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (accept),
    .raddr (bus.flip_addr),
    .rdata (master_rdata)
  );

  assign bus.init_done  = init_done_q;
  assign bus.ready      = ready_q;
  assign bus.flip_ready = ready_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = (byp_q & byp_val_q) | (~byp_q & rep_rdata);

endmodule
